// File: rtl/star_pickup_ctrl_pkg.sv
// Shared game definitions: pickup FSM states, screen bounds and the coordinate type.
package game_pkg;

  typedef enum logic [1:0] {
    ARMED        = 2'd0,
    HOLD         = 2'd1,
    WAIT_DESPAWN = 2'd2
  } pickup_state_t;

  localparam int X_MIN = 0;
  localparam int X_MAX = 639;
  localparam int Y_MIN = 0;
  localparam int Y_MAX = 479;

  typedef logic signed [10:0] coord_t;

endpackage

// File: rtl/star_pickup_ctrl_if.sv
// Box geometry and score bus between the game logic and the pickup controller.
interface star_pickup_ctrl_if;
  import game_pkg::*;

  logic        clear_score;
  coord_t      PlayerX, PlayerY;
  logic [10:0] PlayerW, PlayerH;
  coord_t      StarX, StarY;
  logic [10:0] StarW, StarH;
  logic        starLive;
  logic        collect;
  logic        pickup_pulse;
  logic [2:0]  streak;
  logic [13:0] score;

  modport master (
    output clear_score, PlayerX, PlayerY, PlayerW, PlayerH,
    output StarX, StarY, StarW, StarH, starLive,
    input  collect, pickup_pulse, streak, score
  );

  modport slave (
    input  clear_score, PlayerX, PlayerY, PlayerW, PlayerH,
    input  StarX, StarY, StarW, StarH, starLive,
    output collect, pickup_pulse, streak, score
  );

endinterface

// File: rtl/star_pickup_ctrl_overlap.sv
// Combinational axis-aligned overlap test between two signed boxes.
module box_overlap
  import game_pkg::*;
(
  input  coord_t      i_ax,
  input  coord_t      i_ay,
  input  logic [10:0] i_aw,
  input  logic [10:0] i_ah,
  input  coord_t      i_bx,
  input  coord_t      i_by,
  input  logic [10:0] i_bw,
  input  logic [10:0] i_bh,
  output logic        o_overlap
);

  // Edges are widened to 12 bits so a parked star at -100 cannot wrap.
  function automatic logic signed [11:0] sx12(coord_t v);
    return {v[10], v};
  endfunction

  function automatic logic signed [11:0] end12(coord_t v, logic [10:0] s);
    return sx12(v) + $signed({1'b0, s});
  endfunction

  logic w_nonzero;
  logic w_x_hit;
  logic w_y_hit;

  assign w_nonzero = (i_aw != '0) && (i_ah != '0) && (i_bw != '0) && (i_bh != '0);
  assign w_x_hit   = (sx12(i_bx) < end12(i_ax, i_aw)) && (sx12(i_ax) < end12(i_bx, i_bw));
  assign w_y_hit   = (sx12(i_by) < end12(i_ay, i_ah)) && (sx12(i_ay) < end12(i_by, i_bh));
  assign o_overlap = w_nonzero && w_x_hit && w_y_hit;

endmodule

// File: rtl/star_pickup_ctrl.sv
// Per-frame star pickup detector: held collect pulse, pickup streak and saturating score.
module star_pickup_ctrl
  import game_pkg::*;
#(
  parameter int HOLD_FRAMES = 4,
  parameter int BASE_POINTS = 10,
  parameter int MAX_STREAK  = 7,
  parameter int SCORE_MAX   = 9999
)(
  input  logic                frame_clk,
  input  logic                Reset,
  star_pickup_ctrl_if.slave   bus
);

  pickup_state_t r_state;
  logic          r_collect;
  logic          r_pulse;
  logic [2:0]    r_streak;
  logic [13:0]   r_score;
  logic [3:0]    r_hold_cnt;
  logic          r_live_d;

  logic          w_overlap;
  logic          w_pickup;
  logic          w_expiry;

  box_overlap u_overlap (
    .i_ax      (bus.PlayerX),
    .i_ay      (bus.PlayerY),
    .i_aw      (bus.PlayerW),
    .i_ah      (bus.PlayerH),
    .i_bx      (bus.StarX),
    .i_by      (bus.StarY),
    .i_bw      (bus.StarW),
    .i_bh      (bus.StarH),
    .o_overlap (w_overlap)
  );

  function automatic logic [13:0] pickup_points(logic [2:0] s);
    logic [13:0] mult;
    mult = {11'b0, s} + 14'd1;
    return 14'(BASE_POINTS) * mult;
  endfunction

  function automatic logic [13:0] sat_score(logic [13:0] a, logic [13:0] b);
    logic [14:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : sum[13:0];
  endfunction

  function automatic logic [2:0] sat_streak(logic [2:0] s);
    return (s >= 3'(MAX_STREAK)) ? 3'(MAX_STREAK) : s + 3'd1;
  endfunction

  assign w_pickup = (r_state == ARMED) && bus.starLive && w_overlap;
  // A fall outside ARMED is the star despawning after our own pickup.
  assign w_expiry = (r_state == ARMED) && r_live_d && !bus.starLive;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ARMED;
      r_collect  <= 1'b0;
      r_pulse    <= 1'b0;
      r_streak   <= '0;
      r_score    <= '0;
      r_hold_cnt <= '0;
      r_live_d   <= 1'b0;
    end else begin
      r_live_d <= bus.starLive;
      r_pulse  <= 1'b0;
      case (r_state)
        ARMED: begin
          if (w_pickup) begin
            r_state    <= HOLD;
            r_collect  <= 1'b1;
            r_pulse    <= 1'b1;
            r_hold_cnt <= 4'(HOLD_FRAMES - 1);
            r_score    <= sat_score(r_score, pickup_points(r_streak));
            r_streak   <= sat_streak(r_streak);
          end else if (w_expiry) begin
            r_streak <= '0;
          end
        end
        HOLD: begin
          if (r_hold_cnt == '0) begin
            r_collect <= 1'b0;
            r_state   <= WAIT_DESPAWN;
          end else begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
          end
        end
        WAIT_DESPAWN: begin
          if (!bus.starLive) r_state <= ARMED;
        end
        default: r_state <= ARMED;
      endcase
      if (bus.clear_score) begin
        r_score  <= '0;
        r_streak <= '0;
      end
    end
  end

  assign bus.collect      = r_collect;
  assign bus.pickup_pulse = r_pulse;
  assign bus.streak       = r_streak;
  assign bus.score        = r_score;

endmodule

// File: tb/tb_star_pickup_ctrl.sv
// Scoreboard bench for star_pickup_ctrl: a frame model pushes expected outputs, DUT outputs are popped and compared.
module tb_star_pickup_ctrl;

  localparam int HF = 4;

  typedef struct {
    int collect;
    int pulse;
    int streak;
    int score;
  } exp_t;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;

  star_pickup_ctrl_if bus ();

  star_pickup_ctrl #(
    .HOLD_FRAMES (HF),
    .BASE_POINTS (10),
    .MAX_STREAK  (7),
    .SCORE_MAX   (9999)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // Stimulus held as ints; the model works in unbounded integer arithmetic.
  int px, py, pw, ph, sx, sy, sw, sh;
  int live, clr;

  int m_state, m_collect, m_pulse, m_streak, m_score, m_hold, m_live_d;
  int collect_frames;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.PlayerX     = 11'(px);
    bus.PlayerY     = 11'(py);
    bus.PlayerW     = 11'(pw);
    bus.PlayerH     = 11'(ph);
    bus.StarX       = 11'(sx);
    bus.StarY       = 11'(sy);
    bus.StarW       = 11'(sw);
    bus.StarH       = 11'(sh);
    bus.starLive    = live[0];
    bus.clear_score = clr[0];
  endtask

  function automatic int model_overlap();
    if (pw == 0 || ph == 0 || sw == 0 || sh == 0) return 0;
    return (sx < px + pw && px < sx + sw && sy < py + ph && py < sy + sh) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_collect = 0; m_pulse = 0; m_streak = 0;
    m_score = 0; m_hold = 0; m_live_d = 0;
  endtask

  task automatic model_step();
    int ovl;
    int prev_live;
    ovl       = model_overlap();
    prev_live = m_live_d;
    m_live_d  = live;
    m_pulse   = 0;
    case (m_state)
      0: begin
        if (live != 0 && ovl != 0) begin
          m_state   = 1;
          m_collect = 1;
          m_pulse   = 1;
          m_hold    = HF - 1;
          m_score   = m_score + 10 * (m_streak + 1);
          if (m_score > 9999) m_score = 9999;
          m_streak  = (m_streak < 7) ? m_streak + 1 : 7;
        end else if (prev_live != 0 && live == 0) begin
          m_streak = 0;
        end
      end
      1: begin
        if (m_hold == 0) begin
          m_collect = 0;
          m_state   = 2;
        end else begin
          m_hold = m_hold - 1;
        end
      end
      default: if (live == 0) m_state = 0;
    endcase
    if (clr != 0) begin
      m_score  = 0;
      m_streak = 0;
    end
  endtask

  // One frame: drive, push the model's prediction, clock, pop and compare.
  task automatic frame(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      drive();
      model_step();
      e.collect = m_collect;
      e.pulse   = m_pulse;
      e.streak  = m_streak;
      e.score   = m_score;
      sb_q.push_back(e);
      @(posedge frame_clk);
      #1;
      e = sb_q.pop_front();
      chk("collect", int'(bus.collect), e.collect);
      chk("pickup_pulse", int'(bus.pickup_pulse), e.pulse);
      chk("streak", int'(bus.streak), e.streak);
      chk("score", int'(bus.score), e.score);
      if (bus.collect) collect_frames++;
      #3;
    end
  endtask

  task automatic set_overlap_boxes();
    px = 100; py = 100; pw = 32; ph = 32;
    sx = 120; sy = 110; sw = 40; sh = 38;
  endtask

  task automatic do_pickup();
    set_overlap_boxes();
    live = 1;
    frame(HF + 2);
    live = 0;
    frame(2);
  endtask

  initial begin
    model_reset();
    set_overlap_boxes();
    live = 0;
    clr  = 0;
    drive();
    collect_frames = 0;

    repeat (2) @(posedge frame_clk);
    #1;
    chk("rst_collect", int'(bus.collect), 0);
    chk("rst_pulse", int'(bus.pickup_pulse), 0);
    chk("rst_streak", int'(bus.streak), 0);
    chk("rst_score", int'(bus.score), 0);
    @(negedge frame_clk);
    Reset = 1'b0;
    #1;

    // First pickup, overlap held for 10 frames with the star still live.
    live = 1;
    collect_frames = 0;
    frame(10);
    chk("collect_len", collect_frames, HF);
    chk("first_score", int'(bus.score), 10);
    chk("first_streak", int'(bus.streak), 1);
    live = 0;
    frame(2);

    // Two further pickups without expiry.
    do_pickup();
    chk("second_score", int'(bus.score), 30);
    do_pickup();
    chk("third_score", int'(bus.score), 60);
    chk("third_streak", int'(bus.streak), 3);

    // Expiry: star lives then vanishes while not touched.
    sx = 400; sy = 300;
    live = 1;
    frame(2);
    live = 0;
    frame(1);
    chk("expiry_streak", int'(bus.streak), 0);
    chk("expiry_score", int'(bus.score), 60);

    // Drive the score into saturation and the streak to its cap.
    for (int k = 0; k < 135; k++) do_pickup();
    chk("sat_score", int'(bus.score), 9999);
    chk("sat_streak", int'(bus.streak), 7);

    // Parked offscreen star must not wrap into a hit.
    sx = -100; sy = -100; sw = 40; sh = 38;
    px = 0; py = 0; pw = 32; ph = 32;
    live = 1;
    frame(3);
    chk("parked_no_collect", int'(bus.collect), 0);
    px = -70; py = -70;
    frame(1);
    chk("signed_hit_collect", int'(bus.collect), 1);
    frame(HF + 1);
    live = 0;
    frame(2);

    // Zero-width player inside the star never overlaps.
    set_overlap_boxes();
    px = 130; pw = 0;
    live = 1;
    frame(2);
    chk("zero_w_collect", int'(bus.collect), 0);
    live = 0;
    frame(1);

    // clear_score on a pickup edge.
    set_overlap_boxes();
    live = 1;
    clr  = 1;
    frame(1);
    clr  = 0;
    chk("clr_collect", int'(bus.collect), 1);
    chk("clr_score", int'(bus.score), 0);
    chk("clr_streak", int'(bus.streak), 0);
    frame(1);

    // Asynchronous reset in the middle of HOLD.
    #1;
    Reset = 1'b1;
    #1;
    model_reset();
    chk("arst_collect", int'(bus.collect), 0);
    chk("arst_score", int'(bus.score), 0);
    @(negedge frame_clk);
    Reset = 1'b0;
    #1;
    frame(1);
    chk("post_rst_rearm", int'(bus.collect), 1);
    chk("post_rst_score", int'(bus.score), 10);
    frame(HF + 1);
    live = 0;
    frame(2);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
